// File: rtl/lock_sequence_fsm_pkg.sv
// -----------------------------------------------------------------------------
// lock_pkg
// Definitions shared by the lock sequencer and the downstream output decoder:
//   - DIGIT_W : width of one keypad digit
//   - state_e : the 4-bit Present_State encodings. UNLOCKED (0011) and
//               ALARM (0111) are decoded directly by the output stage and must
//               never move.
//   - is_entry_state() : states in which the entry-timeout timer is active
// -----------------------------------------------------------------------------
package lock_pkg;

  localparam int unsigned DIGIT_W = 4;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'b0000,
    ST_D1_OK    = 4'b0001,
    ST_D2_OK    = 4'b0010,
    ST_UNLOCKED = 4'b0011,
    ST_ERR1     = 4'b0100,
    ST_ERR2     = 4'b0101,
    ST_FAIL     = 4'b0110,
    ST_ALARM    = 4'b0111
  } state_e;

  // An entry is in progress (at least one digit taken, fewer than three).
  function automatic logic is_entry_state(input state_e s);
    return (s inside {ST_D1_OK, ST_D2_OK, ST_ERR1, ST_ERR2});
  endfunction

endpackage

// File: rtl/lock_sequence_fsm_if.sv
// -----------------------------------------------------------------------------
// lock_sequence_fsm_if
// Keypad-side inputs and decoder-side outputs of the lock sequencer.
//   Key_Valid     : one-cycle strobe, a digit is present
//   Key_Value     : digit value, meaningful only with Key_Valid
//   Lock_Cmd      : level request to relock early from UNLOCKED
//   Present_State : registered state code for the output decoder
//   Fail_Count    : registered count of consecutive failed entries
// Modports: master = keypad/controller side, slave = the sequencer.
// -----------------------------------------------------------------------------
interface lock_sequence_fsm_if;
  import lock_pkg::*;

  logic               Key_Valid;
  logic [DIGIT_W-1:0] Key_Value;
  logic               Lock_Cmd;
  logic [3:0]         Present_State;
  logic [3:0]         Fail_Count;

  modport master (
    output Key_Valid, Key_Value, Lock_Cmd,
    input  Present_State, Fail_Count
  );

  modport slave (
    input  Key_Valid, Key_Value, Lock_Cmd,
    output Present_State, Fail_Count
  );

endinterface

// File: rtl/lock_sequence_fsm_timer.sv
// -----------------------------------------------------------------------------
// lock_cycle_timer
// Loadable down-counter measuring an interval in clock cycles.
//   clk_i     : clock, rising edge
//   clear_i   : synchronous clear to zero (highest priority, also the reset)
//   start_i   : load load_i; the loaded value counts the cycle after this edge
//               as cycle 1
//   load_i    : interval length in cycles
//   expired_o : high during the last cycle of the interval (count == 1), so a
//               consumer acting on it at the next edge ends the interval after
//               exactly load_i cycles
// The counter parks at zero once the interval is used up.
// -----------------------------------------------------------------------------
module lock_cycle_timer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             clear_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] load_i,
  output logic             expired_o
);

  logic [WIDTH-1:0] count_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of evaluation order.
  always_ff @(posedge clk_i) begin
    if (clear_i) begin
      count_q <= '0;
    end else if (start_i) begin
      count_q <= load_i;
    end else if (count_q != '0) begin
      count_q <= count_q - 1'b1;
    end
  end

  assign expired_o = (count_q == WIDTH'(1));

endmodule

// File: rtl/lock_sequence_fsm.sv
// -----------------------------------------------------------------------------
// lock_sequence_fsm
// State register and next-state logic of the automatic lock. Checks a 3-digit
// combination entered on the keypad, unlocks for a fixed hold time, counts
// consecutive failed entries and latches ALARM once MAX_ATTEMPTS is reached.
//   Clock : system clock, rising edge
//   Reset : synchronous, active-high; overrides every other event
//   bus   : slave side of lock_sequence_fsm_if (keys in, state/count out)
// Both outputs come straight from registers; there is no combinational path
// from any input to Present_State or Fail_Count.
// -----------------------------------------------------------------------------
module lock_sequence_fsm
  import lock_pkg::*;
#(
  parameter logic [DIGIT_W-1:0] CODE_D0       = 4'd1,
  parameter logic [DIGIT_W-1:0] CODE_D1       = 4'd2,
  parameter logic [DIGIT_W-1:0] CODE_D2       = 4'd3,
  parameter int unsigned        MAX_ATTEMPTS  = 3,     // 1..15
  parameter int unsigned        UNLOCK_CYCLES = 16,    // >= 1
  parameter int unsigned        ENTRY_TIMEOUT = 1000   // >= 2
) (
  input logic                 Clock,
  input logic                 Reset,
  lock_sequence_fsm_if.slave  bus
);

  localparam int unsigned ENTRY_W  = $clog2(ENTRY_TIMEOUT + 1);
  localparam int unsigned UNLOCK_W = $clog2(UNLOCK_CYCLES + 1);

  localparam logic [ENTRY_W-1:0]  ENTRY_LOAD  = ENTRY_W'(ENTRY_TIMEOUT);
  localparam logic [UNLOCK_W-1:0] UNLOCK_LOAD = UNLOCK_W'(UNLOCK_CYCLES);
  localparam logic [3:0]          MAX_FAILS   = 4'(MAX_ATTEMPTS);

  state_e     state_q;
  logic [3:0] fail_q;
  logic [3:0] fail_d;

  logic               key_valid;
  logic [DIGIT_W-1:0] key_value;
  logic               lock_cmd;

  logic entry_start, entry_clear, entry_expired;
  logic unlock_start, unlock_clear, unlock_expired;

  assign key_valid = bus.Key_Valid;
  assign key_value = bus.Key_Value;
  assign lock_cmd  = bus.Lock_Cmd;

  // Saturating increment applied when leaving FAIL.
  assign fail_d = (fail_q >= MAX_FAILS) ? MAX_FAILS : fail_q + 4'd1;

  // ---------------------------------------------------------------------------
  // Timer control. Every key that lands in an entry state (D1_OK, D2_OK, ERR1,
  // ERR2) restarts the idle window; the third key of an entry leaves the entry
  // states, so the window is dropped there.
  // ---------------------------------------------------------------------------
  assign entry_start = key_valid && (state_q inside {ST_IDLE, ST_D1_OK, ST_ERR1});
  assign entry_clear = Reset || (key_valid && (state_q inside {ST_D2_OK, ST_ERR2}));

  assign unlock_start = key_valid && (state_q == ST_D2_OK) && (key_value == CODE_D2);
  // An early relock abandons the remaining hold time.
  assign unlock_clear = Reset || ((state_q == ST_UNLOCKED) && lock_cmd);

  lock_cycle_timer #(.WIDTH(ENTRY_W)) u_entry_timer (
    .clk_i     (Clock),
    .clear_i   (entry_clear),
    .start_i   (entry_start),
    .load_i    (ENTRY_LOAD),
    .expired_o (entry_expired)
  );

  lock_cycle_timer #(.WIDTH(UNLOCK_W)) u_unlock_timer (
    .clk_i     (Clock),
    .clear_i   (unlock_clear),
    .start_i   (unlock_start),
    .load_i    (UNLOCK_LOAD),
    .expired_o (unlock_expired)
  );

  // ---------------------------------------------------------------------------
  // Sequencer. In the entry states a key always takes precedence over an
  // expiring idle window.
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clock) begin
    // NOTE: reset is tested first inside the clocked block, so it is sampled
    // synchronously and beats keys, Lock_Cmd, the hold timer and ALARM.
    if (Reset) begin
      state_q <= ST_IDLE;
      fail_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (key_valid) begin
            state_q <= (key_value == CODE_D0) ? ST_D1_OK : ST_ERR1;
          end
        end

        ST_D1_OK: begin
          if (key_valid) begin
            state_q <= (key_value == CODE_D1) ? ST_D2_OK : ST_ERR2;
          end else if (entry_expired) begin
            state_q <= ST_IDLE;
          end
        end

        ST_D2_OK: begin
          if (key_valid) begin
            if (key_value == CODE_D2) begin
              state_q <= ST_UNLOCKED;
              fail_q  <= '0;
            end else begin
              state_q <= ST_FAIL;
            end
          end else if (entry_expired) begin
            state_q <= ST_IDLE;
          end
        end

        // After a wrong digit the remaining digits are only counted, so a
        // failed entry is indistinguishable in length from a correct one.
        ST_ERR1: begin
          if (key_valid) begin
            state_q <= ST_ERR2;
          end else if (entry_expired) begin
            state_q <= ST_IDLE;
          end
        end

        ST_ERR2: begin
          if (key_valid) begin
            state_q <= ST_FAIL;
          end else if (entry_expired) begin
            state_q <= ST_IDLE;
          end
        end

        // Single-cycle bookkeeping state; any key arriving here is dropped.
        ST_FAIL: begin
          fail_q  <= fail_d;
          state_q <= (fail_d == MAX_FAILS) ? ST_ALARM : ST_IDLE;
        end

        ST_UNLOCKED: begin
          if (lock_cmd || unlock_expired) begin
            state_q <= ST_IDLE;
          end
        end

        ST_ALARM: begin
          state_q <= ST_ALARM;
        end

        // Codes 1000-1111 recover to IDLE; the failure history is kept.
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.Present_State = state_q;
  assign bus.Fail_Count    = fail_q;

endmodule

// File: tb/tb_lock_sequence_fsm.sv
// -----------------------------------------------------------------------------
// tb_lock_sequence_fsm
// Directed scenarios with literal expectations, followed by a randomized run
// compared cycle by cycle against a behavioural model of the lock. The model
// tracks the entry as "digits taken so far / all correct so far" plus plain
// integer timers and maps that onto the published state codes.
// -----------------------------------------------------------------------------
module tb_lock_sequence_fsm;
  import lock_pkg::*;

  localparam logic [3:0] C0   = 4'd1;
  localparam logic [3:0] C1   = 4'd2;
  localparam logic [3:0] C2   = 4'd3;
  localparam int         MAXA = 3;
  localparam int         UNL  = 16;
  localparam int         TMO  = 1000;

  logic clk = 1'b0;
  logic rst = 1'b0;

  lock_sequence_fsm_if bus ();

  lock_sequence_fsm #(
    .CODE_D0       (C0),
    .CODE_D1       (C1),
    .CODE_D2       (C2),
    .MAX_ATTEMPTS  (MAXA),
    .UNLOCK_CYCLES (UNL),
    .ENTRY_TIMEOUT (TMO)
  ) dut (
    .Clock (clk),
    .Reset (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------------------------------------------------------------------
  // Behavioural model
  // ---------------------------------------------------------------------------
  typedef enum {M_ENTRY, M_UNLOCKED, M_FAILING, M_ALARM} mphase_e;

  mphase_e m_phase;
  int      m_digits;   // digits taken in the current entry (0..2)
  bit      m_match;    // every digit so far was correct
  int      m_idle;     // cycles without a key since the last digit
  int      m_elapsed;  // cycles spent unlocked
  int      m_fails;

  function automatic logic [3:0] code_digit(input int idx);
    if (idx == 0) return C0;
    if (idx == 1) return C1;
    return C2;
  endfunction

  task automatic model_reset();
    m_phase   = M_ENTRY;
    m_digits  = 0;
    m_match   = 1'b1;
    m_idle    = 0;
    m_elapsed = 0;
    m_fails   = 0;
  endtask

  task automatic model_step(input bit kv, input logic [3:0] v, input bit lc, input bit r);
    if (r) begin
      model_reset();
      return;
    end
    case (m_phase)
      M_ALARM: ;
      M_FAILING: begin
        if (m_fails < MAXA) m_fails++;
        m_phase  = (m_fails == MAXA) ? M_ALARM : M_ENTRY;
        m_digits = 0;
      end
      M_UNLOCKED: begin
        m_elapsed++;
        if (lc || m_elapsed == UNL) begin
          m_phase  = M_ENTRY;
          m_digits = 0;
        end
      end
      default: begin
        if (kv) begin
          if (m_digits == 0) m_match = 1'b1;
          m_match = m_match && (v == code_digit(m_digits));
          m_digits++;
          m_idle = 0;
          if (m_digits == 3) begin
            if (m_match) begin
              m_phase   = M_UNLOCKED;
              m_elapsed = 0;
              m_fails   = 0;
            end else begin
              m_phase = M_FAILING;
            end
            m_digits = 0;
          end
        end else if (m_digits > 0) begin
          m_idle++;
          if (m_idle == TMO) m_digits = 0;
        end
      end
    endcase
  endtask

  function automatic logic [3:0] model_ps();
    case (m_phase)
      M_ALARM:    return 4'b0111;
      M_UNLOCKED: return 4'b0011;
      M_FAILING:  return 4'b0110;
      default: begin
        if (m_digits == 0) return 4'b0000;
        if (m_digits == 1) return m_match ? 4'b0001 : 4'b0100;
        return m_match ? 4'b0010 : 4'b0101;
      end
    endcase
  endfunction

  // One clock: inputs applied at the falling edge, model advanced at the
  // rising edge, outputs settled and readable when the task returns.
  task automatic cycle(input bit kv, input logic [3:0] v, input bit lc, input bit r);
    @(negedge clk);
    bus.Key_Valid = kv;
    bus.Key_Value = v;
    bus.Lock_Cmd  = lc;
    rst           = r;
    @(posedge clk);
    model_step(kv, v, lc, r);
    #2;
    bus.Key_Valid = 1'b0;
    bus.Lock_Cmd  = 1'b0;
    rst           = 1'b0;
  endtask

  task automatic wrong_entry();
    for (int i = 0; i < 3; i++) cycle(1'b1, 4'd5, 1'b0, 1'b0);
    cycle(1'b0, 4'd0, 1'b0, 1'b0);
  endtask

  task automatic enter_code();
    cycle(1'b1, C0, 1'b0, 1'b0);
    cycle(1'b1, C1, 1'b0, 1'b0);
    cycle(1'b1, C2, 1'b0, 1'b0);
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    cycle(1'b0, 4'd0, 1'b0, 1'b1);
    cycle(1'b0, 4'd0, 1'b0, 1'b1);
    n_checks++;
    if (bus.Present_State !== 4'b0000) begin
      n_fail++; $display("FAIL reset_state: got %b want 0000", bus.Present_State);
    end
    n_checks++;
    if (bus.Fail_Count !== 4'd0) begin
      n_fail++; $display("FAIL reset_count: got %0d want 0", bus.Fail_Count);
    end
  endtask

  task automatic test_unlock();
    logic [3:0] keys [3];
    logic [3:0] exp  [3];
    int bad;
    keys = '{C0, C1, C2};
    exp  = '{4'b0001, 4'b0010, 4'b0011};
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, keys[i], 1'b0, 1'b0);
      n_checks++;
      if (bus.Present_State !== exp[i]) begin
        n_fail++; $display("FAIL unlock_digit%0d: got %b want %b", i, bus.Present_State, exp[i]);
      end
    end
    bad = 0;
    for (int i = 1; i < UNL; i++) begin
      cycle(1'b1, 4'd9, 1'b0, 1'b0);  // keys are ignored while unlocked
      if (bus.Present_State !== 4'b0011) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++; $display("FAIL unlock_hold: %0d of %0d cycles left 0011", bad, UNL - 1);
    end
    cycle(1'b0, 4'd0, 1'b0, 1'b0);
    n_checks++;
    if (bus.Present_State !== 4'b0000) begin
      n_fail++; $display("FAIL unlock_relock: got %b want 0000", bus.Present_State);
    end
    n_checks++;
    if (bus.Fail_Count !== 4'd0) begin
      n_fail++; $display("FAIL unlock_count: got %0d want 0", bus.Fail_Count);
    end
  endtask

  task automatic test_alarm();
    int bad;
    cycle(1'b0, 4'd0, 1'b0, 1'b1);
    for (int a = 1; a <= MAXA; a++) begin
      for (int j = 0; j < 3; j++) begin
        cycle(1'b1, 4'd5, 1'b0, 1'b0);
        n_checks++;
        if (bus.Present_State !== 4'(4 + j)) begin
          n_fail++; $display("FAIL alarm_path a%0d k%0d: got %b want %b", a, j, bus.Present_State, 4'(4 + j));
        end
      end
      cycle(1'b0, 4'd0, 1'b0, 1'b0);
      n_checks++;
      if (bus.Fail_Count !== 4'(a)) begin
        n_fail++; $display("FAIL alarm_count a%0d: got %0d want %0d", a, bus.Fail_Count, a);
      end
      n_checks++;
      if (bus.Present_State !== ((a == MAXA) ? 4'b0111 : 4'b0000)) begin
        n_fail++; $display("FAIL alarm_after a%0d: got %b", a, bus.Present_State);
      end
    end
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      cycle(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 1'(i % 2), 1'b0);
      if (bus.Present_State !== 4'b0111 || bus.Fail_Count !== 4'(MAXA)) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++; $display("FAIL alarm_sticky: %0d cycles left ALARM/MAX", bad);
    end
    cycle(1'b1, C0, 1'b1, 1'b1);
    n_checks++;
    if (bus.Present_State !== 4'b0000 || bus.Fail_Count !== 4'd0) begin
      n_fail++; $display("FAIL alarm_reset: got %b/%0d want 0000/0", bus.Present_State, bus.Fail_Count);
    end
  endtask

  task automatic test_recover();
    cycle(1'b0, 4'd0, 1'b0, 1'b1);
    wrong_entry();
    wrong_entry();
    n_checks++;
    if (bus.Fail_Count !== 4'd2) begin
      n_fail++; $display("FAIL recover_two: got %0d want 2", bus.Fail_Count);
    end
    enter_code();
    n_checks++;
    if (bus.Present_State !== 4'b0011 || bus.Fail_Count !== 4'd0) begin
      n_fail++; $display("FAIL recover_unlock: got %b/%0d want 0011/0", bus.Present_State, bus.Fail_Count);
    end
    cycle(1'b0, 4'd0, 1'b1, 1'b0);
    wrong_entry();
    n_checks++;
    if (bus.Present_State !== 4'b0000 || bus.Fail_Count !== 4'd1) begin
      n_fail++; $display("FAIL recover_fail: got %b/%0d want 0000/1", bus.Present_State, bus.Fail_Count);
    end
  endtask

  task automatic test_timeout();
    cycle(1'b0, 4'd0, 1'b0, 1'b1);
    wrong_entry();
    cycle(1'b1, C0, 1'b0, 1'b0);
    for (int i = 1; i < TMO; i++) cycle(1'b0, 4'd0, 1'b0, 1'b0);
    n_checks++;
    if (bus.Present_State !== 4'b0001) begin
      n_fail++; $display("FAIL timeout_early: got %b want 0001", bus.Present_State);
    end
    cycle(1'b0, 4'd0, 1'b0, 1'b0);
    n_checks++;
    if (bus.Present_State !== 4'b0000 || bus.Fail_Count !== 4'd1) begin
      n_fail++; $display("FAIL timeout_expire: got %b/%0d want 0000/1", bus.Present_State, bus.Fail_Count);
    end
    // Key on the expiry cycle wins and restarts the window.
    cycle(1'b1, C0, 1'b0, 1'b0);
    for (int i = 1; i < TMO; i++) cycle(1'b0, 4'd0, 1'b0, 1'b0);
    cycle(1'b1, C1, 1'b0, 1'b0);
    n_checks++;
    if (bus.Present_State !== 4'b0010) begin
      n_fail++; $display("FAIL timeout_keywins: got %b want 0010", bus.Present_State);
    end
    for (int i = 1; i < TMO; i++) cycle(1'b0, 4'd0, 1'b0, 1'b0);
    n_checks++;
    if (bus.Present_State !== 4'b0010) begin
      n_fail++; $display("FAIL timeout_restart: got %b want 0010", bus.Present_State);
    end
    cycle(1'b0, 4'd0, 1'b0, 1'b0);
    n_checks++;
    if (bus.Present_State !== 4'b0000 || bus.Fail_Count !== 4'd1) begin
      n_fail++; $display("FAIL timeout_second: got %b/%0d want 0000/1", bus.Present_State, bus.Fail_Count);
    end
  endtask

  task automatic test_lock_cmd();
    cycle(1'b0, 4'd0, 1'b0, 1'b1);
    enter_code();
    cycle(1'b0, 4'd0, 1'b0, 1'b0);
    cycle(1'b0, 4'd0, 1'b0, 1'b0);
    n_checks++;
    if (bus.Present_State !== 4'b0011) begin
      n_fail++; $display("FAIL lockcmd_before: got %b want 0011", bus.Present_State);
    end
    cycle(1'b0, 4'd0, 1'b1, 1'b0);
    n_checks++;
    if (bus.Present_State !== 4'b0000) begin
      n_fail++; $display("FAIL lockcmd_relock: got %b want 0000", bus.Present_State);
    end
    enter_code();
    for (int i = 0; i < 4; i++) cycle(1'b0, 4'd0, 1'b0, 1'b0);
    cycle(1'b0, 4'd0, 1'b0, 1'b1);
    n_checks++;
    if (bus.Present_State !== 4'b0000 || bus.Fail_Count !== 4'd0) begin
      n_fail++; $display("FAIL unlocked_reset: got %b/%0d want 0000/0", bus.Present_State, bus.Fail_Count);
    end
    n_checks++;
    if (dut.u_unlock_timer.count_q !== '0) begin
      n_fail++; $display("FAIL unlocked_reset_timer: got %0d want 0", dut.u_unlock_timer.count_q);
    end
  endtask

  task automatic test_fail_drop();
    cycle(1'b0, 4'd0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b1, 4'd5, 1'b0, 1'b0);
    n_checks++;
    if (bus.Present_State !== 4'b0110) begin
      n_fail++; $display("FAIL faildrop_fail: got %b want 0110", bus.Present_State);
    end
    cycle(1'b1, C0, 1'b0, 1'b0);
    n_checks++;
    if (bus.Present_State !== 4'b0000 || bus.Fail_Count !== 4'd1) begin
      n_fail++; $display("FAIL faildrop_idle: got %b/%0d want 0000/1", bus.Present_State, bus.Fail_Count);
    end
  endtask

  task automatic test_illegal();
    @(negedge clk);
    force dut.state_q = state_e'(4'b1010);
    @(posedge clk);
    #2;
    release dut.state_q;
    cycle(1'b0, 4'd0, 1'b0, 1'b0);
    n_checks++;
    if (bus.Present_State !== 4'b0000 || bus.Fail_Count !== 4'd1) begin
      n_fail++; $display("FAIL illegal_recover: got %b/%0d want 0000/1", bus.Present_State, bus.Fail_Count);
    end
  endtask

  task automatic test_random();
    int bad_ps;
    int bad_fc;
    bit kv;
    bit lc;
    bit r;
    logic [3:0] v;
    bad_ps = 0;
    bad_fc = 0;
    cycle(1'b0, 4'd0, 1'b0, 1'b1);
    for (int i = 0; i < 4000; i++) begin
      kv = ($urandom_range(0, 99) < 60);
      v  = ($urandom_range(0, 3) != 0) ? code_digit(m_digits) : 4'($urandom_range(0, 15));
      lc = ($urandom_range(0, 19) == 0);
      r  = ($urandom_range(0, 299) == 0);
      cycle(kv, v, lc, r);
      n_checks += 2;
      if (bus.Present_State !== model_ps()) begin
        n_fail++; bad_ps++;
        if (bad_ps <= 5) $display("FAIL random_state cyc%0d: got %b want %b", i, bus.Present_State, model_ps());
      end
      if (bus.Fail_Count !== 4'(m_fails)) begin
        n_fail++; bad_fc++;
        if (bad_fc <= 5) $display("FAIL random_count cyc%0d: got %0d want %0d", i, bus.Fail_Count, m_fails);
      end
    end
  endtask

  initial begin
    bus.Key_Valid = 1'b0;
    bus.Key_Value = '0;
    bus.Lock_Cmd  = 1'b0;
    model_reset();
    test_reset();
    test_unlock();
    test_alarm();
    test_recover();
    test_timeout();
    test_lock_cmd();
    test_fail_drop();
    test_illegal();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
